// File: rtl/spell_loader_pkg.sv
// Shared types and constants for the spell core boot loader.
// The optional checksum output is enabled with SPELL_LOADER_CHECKSUM_EN.
package spell_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 8;

  // Widest field the shifter ever sends, and the width of its bit counter.
  localparam int SHIFT_W = 24;
  localparam int CNT_W   = 5;

endpackage

// File: rtl/spell_spi_shifter.sv
// SPI mode 0 bit engine: SCK divider plus a left-aligned transmit shift
// register of up to 24 bits and an 8-bit receive shift register.
// A load starts a frame of 'width' bits; each bit is CLK_DIV cycles with SCK
// low followed by CLK_DIV cycles with SCK high. MISO is captured on the edge
// that raises SCK, MOSI advances on the edge that lowers it.
module spell_spi_shifter
  import spell_loader_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [CNT_W-1:0]   width,
  input  logic [SHIFT_W-1:0] tx_data,
  input  logic               miso,
  output logic               sck,
  output logic               mosi,
  output logic [7:0]         rx_byte,
  output logic               active,
  output logic               bit_done,
  output logic               byte_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic               active_reg;
  logic               sck_reg;
  logic [DW-1:0]      div_reg;
  logic [CNT_W-1:0]   bits_reg;
  logic [SHIFT_W-1:0] tx_reg;
  logic [7:0]         rx_reg;
  logic               phase_end;

  assign phase_end = active_reg && (div_reg == DIV_LAST);
  assign bit_done  = phase_end && sck_reg;
  assign byte_done = bit_done && (bits_reg == CNT_W'(1));

  assign sck     = sck_reg;
  assign mosi    = active_reg & tx_reg[SHIFT_W-1];
  assign rx_byte = rx_reg;
  assign active  = active_reg;

  // Divider, SCK phase and both shift registers; a load overrides the frame end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_reg <= 1'b0;
      sck_reg    <= 1'b0;
      div_reg    <= '0;
      bits_reg   <= '0;
      tx_reg     <= '0;
      rx_reg     <= '0;
    end else if (load) begin
      active_reg <= 1'b1;
      sck_reg    <= 1'b0;
      div_reg    <= '0;
      bits_reg   <= width;
      tx_reg     <= tx_data;
    end else if (active_reg) begin
      if (phase_end) begin
        div_reg <= '0;
        if (!sck_reg) begin
          sck_reg <= 1'b1;
          rx_reg  <= {rx_reg[6:0], miso};
        end else begin
          sck_reg  <= 1'b0;
          tx_reg   <= {tx_reg[SHIFT_W-2:0], 1'b0};
          bits_reg <= bits_reg - CNT_W'(1);
          if (bits_reg == CNT_W'(1)) begin
            active_reg <= 1'b0;
          end
        end
      end else begin
        div_reg <= div_reg + DW'(1);
      end
    end
  end

endmodule

// File: rtl/spell_flash_loader.sv
// Boot sequencer: one SPI READ from flash, streaming 'length' bytes into the
// spell core program memory while holding the core in reset.
// Define SPELL_LOADER_CHECKSUM_EN to add an 8-bit sum of the loaded bytes.
module spell_flash_loader
  import spell_loader_pkg::*;
#(
  parameter int         MEM_AW   = 8,
  parameter int         CLK_DIV  = 2,
  parameter logic [7:0] READ_CMD = READ_CMD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       flash_base,
  input  logic [MEM_AW:0]   length,
  output logic              spi_csb,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              core_hold
`ifdef SPELL_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam logic [MEM_AW:0] MAX_LEN = {1'b1, {MEM_AW{1'b0}}};

  state_t             state;
  state_t             state_next;
  logic [23:0]        base_reg;
  logic [MEM_AW:0]    len_reg;
  logic [MEM_AW:0]    index_reg;
  logic [MEM_AW:0]    index_inc;
  logic [MEM_AW:0]    len_clamp;
  logic               done_reg;
  logic               hold_reg;
  logic               accept;
  logic               last_byte;

  logic               sh_load;
  logic [CNT_W-1:0]   sh_width;
  logic [SHIFT_W-1:0] sh_tx;
  logic               sh_active;
  logic               sh_bit_done;
  logic               sh_byte_done;
  logic               frame_end;
  logic [7:0]         sh_rx;

  assign accept    = (state == ST_IDLE) && start;
  assign index_inc = index_reg + 1'b1;
  assign last_byte = (index_inc == len_reg);
  assign len_clamp = (length > MAX_LEN) ? MAX_LEN : length;
  // A frame has finished on the falling SCK edge of its final bit.
  assign frame_end = sh_bit_done & sh_byte_done;

  spell_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (sh_load),
    .width     (sh_width),
    .tx_data   (sh_tx),
    .miso      (spi_miso),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .rx_byte   (sh_rx),
    .active    (sh_active),
    .bit_done  (sh_bit_done),
    .byte_done (sh_byte_done)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each SPI phase advances when its frame completes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = (length == '0) ? ST_FINISH : ST_CMD;
      ST_CMD:    if (frame_end) state_next = ST_ADDR;
      ST_ADDR:   if (frame_end) state_next = ST_DATA;
      ST_DATA:   if (frame_end) state_next = ST_WRITE;
      ST_WRITE:  state_next = last_byte ? ST_FINISH : ST_DATA;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs and shifter loads. The first CMD cycle only loads the opcode;
  // later frames are loaded on the edge the previous one ends so no SCK
  // cycles are lost between command, address and data bytes.
  always_comb begin
    spi_csb  = 1'b1;
    busy     = 1'b1;
    mem_we   = 1'b0;
    sh_load  = 1'b0;
    sh_width = CNT_W'(DATA_BITS);
    sh_tx    = '0;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_CMD: begin
        spi_csb = 1'b0;
        if (!sh_active) begin
          sh_load  = 1'b1;
          sh_width = CNT_W'(CMD_BITS);
          sh_tx    = {READ_CMD, {(SHIFT_W-CMD_BITS){1'b0}}};
        end else if (frame_end) begin
          sh_load  = 1'b1;
          sh_width = CNT_W'(ADDR_BITS);
          sh_tx    = base_reg;
        end
      end
      ST_ADDR: begin
        spi_csb = 1'b0;
        sh_load = frame_end;
      end
      ST_DATA: spi_csb = 1'b0;
      ST_WRITE: begin
        spi_csb = 1'b0;
        mem_we  = 1'b1;
        sh_load = !last_byte;
      end
      ST_FINISH: spi_csb = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Request latch, byte index, completion pulse and core hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_reg  <= '0;
      len_reg   <= '0;
      index_reg <= '0;
      done_reg  <= 1'b0;
      hold_reg  <= 1'b1;
    end else begin
      done_reg <= (state == ST_FINISH);
      if (accept) begin
        base_reg <= flash_base;
        len_reg  <= len_clamp;
        hold_reg <= 1'b1;
      end
      if (state == ST_WRITE) begin
        index_reg <= index_inc;
      end
      if (state == ST_FINISH) begin
        index_reg <= '0;
        hold_reg  <= 1'b0;
      end
    end
  end

  assign mem_addr  = index_reg[MEM_AW-1:0];
  assign mem_wdata = sh_rx;
  assign done      = done_reg;
  assign core_hold = hold_reg;

`ifdef SPELL_LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;

  // Running modulo-256 sum of written bytes, restarted by each accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_reg <= '0;
    end else if (accept) begin
      sum_reg <= '0;
    end else if (state == ST_WRITE) begin
      sum_reg <= sum_reg + sh_rx;
    end
  end

  assign checksum = sum_reg;
`endif

endmodule

// File: tb/tb_spell_flash_loader.sv
// Self-checking bench for spell_flash_loader with a behavioural SPI flash.
// Build with SPELL_LOADER_CHECKSUM_EN defined to also exercise the checksum.
module tb_spell_flash_loader;

  localparam int MEM_AW  = 8;
  localparam int CLK_DIV = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [23:0]       flash_base = '0;
  logic [MEM_AW:0]   length = '0;
  logic              spi_miso = 1'b0;
  logic              spi_csb, spi_sck, spi_mosi;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy, done, core_hold;
`ifdef SPELL_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  spell_flash_loader #(
    .MEM_AW  (MEM_AW),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .flash_base (flash_base),
    .length     (length),
    .spi_csb    (spi_csb),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .core_hold  (core_hold)
`ifdef SPELL_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int start_cyc = 0;

  always @(posedge clock) cycle_cnt++;

  // Flash content: explicit overrides, otherwise a seeded address hash.
  logic [7:0] flash_ovr [logic [23:0]];
  logic [7:0] seed = 8'h5A;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (flash_ovr.exists(a)) return flash_ovr[a];
    return 8'(a * 37) ^ 8'(a >> 9) ^ seed;
  endfunction

  // Reference latency from the load rules: command, address, per-byte
  // transfer plus write, then the finish and done cycles.
  function automatic int exp_lat(input int len);
    int eff;
    eff = (len > (1 << MEM_AW)) ? (1 << MEM_AW) : len;
    if (len == 0) return 2;
    return 1 + 64 * CLK_DIV + eff * (16 * CLK_DIV + 1) + 2;
  endfunction

  // Behavioural SPI flash: 8-bit opcode and 24-bit address captured on SCK
  // rise, data bits presented MSB first on SCK fall, address auto-increments.
  int          fl_bits = 0;
  int          fl_out = 0;
  int          data_mosi_ones = 0;
  logic [31:0] fl_hdr = '0;
  logic [7:0]  cap_cmd = '0;
  logic [23:0] cap_addr = '0;
  logic [7:0]  fl_byte;

  always @(posedge spi_sck or negedge spi_sck or posedge spi_csb) begin
    if (spi_csb !== 1'b0) begin
      fl_bits  = 0;
      fl_out   = 0;
      spi_miso = 1'b0;
    end else if (spi_sck === 1'b1) begin
      if (fl_bits < 32) begin
        fl_hdr = {fl_hdr[30:0], spi_mosi};
        fl_bits++;
        if (fl_bits == 32) begin
          cap_cmd  = fl_hdr[31:24];
          cap_addr = fl_hdr[23:0];
        end
      end else if (spi_mosi !== 1'b0) begin
        data_mosi_ones++;
      end
    end else if (fl_bits >= 32) begin
      fl_byte  = flash_byte(cap_addr + 24'(fl_out / 8));
      spi_miso = fl_byte[7 - (fl_out % 8)];
      fl_out++;
    end
  end

  // Bus monitor sampled mid-cycle.
  typedef struct { int addr; int data; } wr_t;
  wr_t  wr_q[$];
  int   done_pulses = 0;
  int   csb_falls = 0;
  int   mosi_glitch = 0;
  logic prev_sck = 1'b0, prev_mosi = 1'b0, prev_csb = 1'b1;

  always @(negedge clock) begin
    if (mem_we === 1'b1) wr_q.push_back('{int'(mem_addr), int'(mem_wdata)});
    if (done === 1'b1) done_pulses++;
    if (prev_csb === 1'b1 && spi_csb === 1'b0) csb_falls++;
    if (prev_sck === 1'b1 && spi_sck === 1'b1 && spi_mosi !== prev_mosi) mosi_glitch++;
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
    prev_csb  = spi_csb;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers (no checking inside).
  task automatic begin_load(input logic [23:0] b, input int len);
    flash_base = b;
    length     = (MEM_AW+1)'(len);
    start      = 1'b1;
    start_cyc  = cycle_cnt;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit to);
    to  = 1'b1;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        to  = 1'b0;
        lat = cycle_cnt - start_cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({spi_csb, spi_sck, spi_mosi, mem_we, busy, done, core_hold} !== 7'b1000001) begin
      errors++;
      $display("FAIL reset_ctrl: got csb,sck,mosi,we,busy,done,hold=%b required 1000001",
               {spi_csb, spi_sck, spi_mosi, mem_we, busy, done, core_hold});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got addr=%0h wdata=%0h required 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    int lat; bit to; int w0; int d0; int g0; int m0;
    flash_ovr[24'h001000] = 8'hA1;
    flash_ovr[24'h001001] = 8'hB2;
    flash_ovr[24'h001002] = 8'hC3;
    flash_ovr[24'h001003] = 8'hD4;
    w0 = wr_q.size(); d0 = done_pulses; g0 = mosi_glitch; m0 = data_mosi_ones;
    begin_load(24'h001000, 4);
    checks++;
    if ({spi_csb, busy, core_hold} !== 3'b011) begin
      errors++;
      $display("FAIL basic_start: got csb,busy,hold=%b required 011", {spi_csb, busy, core_hold});
    end
    wait_done(1000, lat, to);
    checks++;
    if (to || lat != 263) begin
      errors++;
      $display("FAIL basic_latency: got %0d (timeout=%0d) required 263", lat, to);
    end
    checks++;
    if (core_hold !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got core_hold=%b at done required 0", core_hold);
    end
    checks++;
    if ({cap_cmd, cap_addr} !== 32'h03001000) begin
      errors++;
      $display("FAIL basic_mosi: got %h required 03001000", {cap_cmd, cap_addr});
    end
    checks++;
    if (wr_q.size() - w0 != 4) begin
      errors++;
      $display("FAIL basic_wcount: got %0d writes required 4", wr_q.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_q[w0+i].addr != i || wr_q[w0+i].data != int'(flash_byte(24'h001000 + 24'(i)))) begin
          errors++;
          $display("FAIL basic_write%0d: got addr=%0d data=%02h required addr=%0d data=%02h",
                   i, wr_q[w0+i].addr, wr_q[w0+i].data, i, flash_byte(24'h001000 + 24'(i)));
        end
      end
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || done_pulses - d0 != 1) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b pulses=%0d required 0 and 1", done, done_pulses - d0);
    end
    checks++;
    if (mosi_glitch != g0 || data_mosi_ones != m0) begin
      errors++;
      $display("FAIL basic_mode0: got glitches=%0d data_mosi_ones=%0d required 0/0",
               mosi_glitch - g0, data_mosi_ones - m0);
    end
    $display("test_basic: latency %0d, %0d writes", lat, wr_q.size() - w0);
  endtask

  task automatic test_zero_length();
    int lat; bit to; int w0; int c0;
    w0 = wr_q.size(); c0 = csb_falls;
    begin_load(24'($urandom), 0);
    wait_done(20, lat, to);
    checks++;
    if (to || lat != 2) begin
      errors++;
      $display("FAIL zero_latency: got %0d (timeout=%0d) required 2", lat, to);
    end
    @(negedge clock);
    checks++;
    if (csb_falls != c0 || wr_q.size() != w0) begin
      errors++;
      $display("FAIL zero_bus: got csb_falls=%0d writes=%0d required 0/0", csb_falls - c0, wr_q.size() - w0);
    end
    $display("test_zero_length: latency %0d", lat);
  endtask

  task automatic test_random();
    int lat; bit to; int w0; int len; int bad; logic [23:0] b;
    seed = 8'($urandom);
    for (int n = 0; n < 4; n++) begin
      b   = 24'($urandom);
      len = $urandom_range(1, 12);
      w0  = wr_q.size();
      begin_load(b, len);
      wait_done(exp_lat(len) + 50, lat, to);
      checks++;
      if (to || lat != exp_lat(len)) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d (timeout=%0d) required %0d", n, lat, to, exp_lat(len));
      end
      checks++;
      if ({cap_cmd, cap_addr} !== {8'h03, b}) begin
        errors++;
        $display("FAIL rand%0d_header: got %h required %h", n, {cap_cmd, cap_addr}, {8'h03, b});
      end
      bad = 0;
      if (wr_q.size() - w0 == len) begin
        for (int i = 0; i < len; i++)
          if (wr_q[w0+i].addr != i || wr_q[w0+i].data != int'(flash_byte(b + 24'(i)))) bad++;
      end
      checks++;
      if (wr_q.size() - w0 != len || bad != 0) begin
        errors++;
        $display("FAIL rand%0d_writes: got %0d writes, %0d wrong, required %0d writes, 0 wrong",
                 n, wr_q.size() - w0, bad, len);
      end
      $display("test_random: base %06h len %0d latency %0d", b, len, lat);
      @(negedge clock);
    end
  endtask

  task automatic test_full(input int len);
    int lat; bit to; int w0; int d0; int bad; int cnt; logic [23:0] b;
    b  = 24'($urandom);
    w0 = wr_q.size(); d0 = done_pulses;
    begin_load(b, len);
    wait_done(exp_lat(len) + 100, lat, to);
    @(negedge clock);
    cnt = wr_q.size() - w0;
    checks++;
    if (to || lat != exp_lat(len)) begin
      errors++;
      $display("FAIL full%0d_latency: got %0d (timeout=%0d) required %0d", len, lat, to, exp_lat(len));
    end
    bad = 0;
    for (int i = 0; i < cnt; i++)
      if (wr_q[w0+i].addr != i || wr_q[w0+i].data != int'(flash_byte(b + 24'(i)))) bad++;
    checks++;
    if (cnt != 256 || bad != 0) begin
      errors++;
      $display("FAIL full%0d_writes: got %0d writes, %0d wrong, required 256 writes, 0 wrong", len, cnt, bad);
    end
    checks++;
    if (cnt == 0 || wr_q[wr_q.size()-1].addr != 255 || done_pulses - d0 != 1) begin
      errors++;
      $display("FAIL full%0d_end: got last addr=%0d done pulses=%0d required 255 and 1",
               len, (cnt == 0) ? -1 : wr_q[wr_q.size()-1].addr, done_pulses - d0);
    end
    $display("test_full: length %0d latency %0d writes %0d", len, lat, cnt);
  endtask

  task automatic test_start_during_data();
    int lat; bit to; int w0; int d0; int bad; logic [23:0] b;
    b  = 24'($urandom);
    w0 = wr_q.size(); d0 = done_pulses;
    begin_load(b, 6);
    repeat (200) @(negedge clock);
    flash_base = ~b;
    length     = (MEM_AW+1)'(3);
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(exp_lat(6) + 50, lat, to);
    @(negedge clock);
    checks++;
    if (to || lat != exp_lat(6)) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d (timeout=%0d) required %0d", lat, to, exp_lat(6));
    end
    bad = 0;
    if (wr_q.size() - w0 == 6) begin
      for (int i = 0; i < 6; i++)
        if (wr_q[w0+i].addr != i || wr_q[w0+i].data != int'(flash_byte(b + 24'(i)))) bad++;
    end
    checks++;
    if (wr_q.size() - w0 != 6 || bad != 0 || done_pulses - d0 != 1) begin
      errors++;
      $display("FAIL busy_start_writes: got %0d writes, %0d wrong, %0d done required 6, 0, 1",
               wr_q.size() - w0, bad, done_pulses - d0);
    end
    $display("test_start_during_data: latency %0d", lat);
  endtask

  task automatic test_reset_mid();
    int lat; bit to; int w0; int ws; bit reached; logic [23:0] b;
    w0 = wr_q.size();
    begin_load(24'($urandom), 10);
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (wr_q.size() - w0 >= 2) begin reached = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL midreset_progress: got %0d writes required at least 2", wr_q.size() - w0);
    end
    repeat (7) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({spi_csb, spi_sck, spi_mosi, mem_we, busy, done, core_hold} !== 7'b1000001) begin
      errors++;
      $display("FAIL midreset_bus: got csb,sck,mosi,we,busy,done,hold=%b required 1000001",
               {spi_csb, spi_sck, spi_mosi, mem_we, busy, done, core_hold});
    end
    ws = wr_q.size();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (wr_q.size() != ws) begin
      errors++;
      $display("FAIL midreset_we: got %0d writes during reset required 0", wr_q.size() - ws);
    end
    @(negedge clock);
    b  = 24'($urandom);
    w0 = wr_q.size();
    begin_load(b, 2);
    wait_done(exp_lat(2) + 50, lat, to);
    checks++;
    if (to || lat != exp_lat(2)) begin
      errors++;
      $display("FAIL rerun_latency: got %0d (timeout=%0d) required %0d", lat, to, exp_lat(2));
    end
    checks++;
    if (wr_q.size() - w0 != 2 ||
        wr_q[w0].addr != 0 || wr_q[w0].data != int'(flash_byte(b)) ||
        wr_q[w0+1].addr != 1 || wr_q[w0+1].data != int'(flash_byte(b + 24'd1))) begin
      errors++;
      $display("FAIL rerun_writes: got %0d writes, required addr 0/1 data %02h/%02h",
               wr_q.size() - w0, flash_byte(b), flash_byte(b + 24'd1));
    end
    @(negedge clock);
    $display("test_reset_mid: rerun latency %0d", lat);
  endtask

`ifdef SPELL_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int lat; bit to;
    flash_ovr[24'h000200] = 8'hFF;
    flash_ovr[24'h000201] = 8'h02;
    begin_load(24'h000200, 2);
    wait_done(exp_lat(2) + 50, lat, to);
    checks++;
    if (to || checksum !== 8'h01) begin
      errors++;
      $display("FAIL checksum: got %02h (timeout=%0d) required 01", checksum, to);
    end
    @(negedge clock);
    $display("test_checksum: checksum %02h", checksum);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_random();
    test_full(256);
    test_full(300);
    test_start_during_data();
    test_reset_mid();
`ifdef SPELL_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spell_flash_loader.md
Name: spell_flash_loader

Overview:
- Boot sequencer that copies a program image from the external SPI flash into the spell core's program memory.
- Issues a single READ (0x03) transaction and streams `length` bytes into memory through a one-cycle write strobe.
- Holds the spell core in reset while loading and releases it afterwards.
- Sits between the user-area SPI pins and the spell core's memory write port inside the wrapper.

Parameters:
- MEM_AW, 8: program memory address width; image length is at most 2**MEM_AW bytes.
- CLK_DIV, 2: SCK half-period in clock cycles; must be at least 1.
- READ_CMD, 8'h03: flash read opcode.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse that begins a load; sampled only in IDLE.
- flash_base  in  24  flash byte address of the image.
- length  in  MEM_AW+1  number of bytes to load, 0 to 2**MEM_AW.
- spi_csb  out  1  flash chip select, active low.
- spi_sck  out  1  SPI clock, mode 0.
- spi_mosi  out  1  serial data to the flash.
- spi_miso  in  1  serial data from the flash.
- mem_we  out  1  one-cycle program memory write strobe.
- mem_addr  out  MEM_AW  write address.
- mem_wdata  out  8  write data.
- busy  out  1  high while the state is not IDLE.
- done  out  1  one-cycle pulse when a load completes.
- core_hold  out  1  holds the spell core in reset.

Behaviour:
- Reset values (asynchronous):
  - spi_csb=1, spi_sck=0, spi_mosi=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, core_hold=1.
  - Internal state = IDLE.
- States: IDLE, CMD, ADDR, DATA, WRITE, FINISH.
- IDLE + start:
  - If length=0: go to FINISH, no SPI activity.
  - Otherwise: the next cycle drives spi_csb=0 and enters CMD. flash_base and length are latched at this point.
- SPI mode 0:
  - SCK idles low.
  - Each bit is CLK_DIV cycles low, then CLK_DIV cycles high.
  - MOSI changes only while SCK is low, and is driven MSB first.
  - MISO is sampled on the cycle SCK rises.
- CMD: shifts READ_CMD, 8 bits, then goes to ADDR.
- ADDR: shifts flash_base, 24 bits MSB first, then goes to DATA. MOSI is held at 0 for the rest of the transaction.
- DATA: shifts in 8 bits, then goes to WRITE, with SCK low.
- WRITE, exactly one cycle:
  - mem_we=1, mem_wdata=assembled byte, mem_addr=byte index.
  - The byte index then increments.
  - If index equals length: go to FINISH; otherwise go back to DATA.
- FINISH, one cycle: spi_csb=1 and the index clears.
- The following cycle: done=1 for one cycle, core_hold=0, state=IDLE.
- Latency: done is asserted T cycles after the cycle start is sampled, where T = 1 + 64*CLK_DIV + length*(16*CLK_DIV+1) + 1 + 1.
- For length=0: done pulses 2 cycles after start, and spi_csb never falls.
- start while busy is ignored. A start in IDLE after a previous load re-asserts core_hold until the new done.
- mem_addr never wraps, because length is bounded by 2**MEM_AW. Values of length above 2**MEM_AW are clamped to 2**MEM_AW.
- Reset mid-transaction: all outputs return to their reset values immediately. No partial mem_we is issued.

Optional Feature:
- Macro: SPELL_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[7:0], an 8-bit modulo-256 sum of all bytes written.
  - The sum clears on start and updates in the WRITE cycle.
  - checksum is valid when done pulses and holds until the next start.
  - Reset value 0.
- When undefined: the port and its logic are absent. All other timing is identical.

Decomposition:
- Package spell_loader_pkg holds:
  - the state enum;
  - the READ_CMD default;
  - localparams CMD_BITS=8, ADDR_BITS=24, DATA_BITS=8.
- Sub-module spell_spi_shifter:
  - Contains the SCK divider and an 8/24-bit shift register.
  - Interface: load, width, tx data, rx byte, bit_done and byte_done strobes.
  - The top module holds the FSM, the index counter and the memory port.

Test Plan:
- Basic load, CLK_DIV=2, flash_base=0x001000, length=4, flash holds 0xA1 0xB2 0xC3 0xD4:
  - MOSI shows 0x03,0x00,0x10,0x00.
  - mem_we fires 4 times with addr 0..3 and data A1,B2,C3,D4.
  - done occurs exactly 1+128+4*33+2=263 cycles after start.
  - core_hold falls with done.
- length=0: spi_csb stays high, done pulses 2 cycles after start, no mem_we.
- Full image, MEM_AW=8, length=256: the last write has addr=255, there is no wrap, and done pulses once.
- start asserted again during DATA: ignored, byte count and addresses unchanged.
- Reset asserted mid-DATA, then released and start issued with length=2: the bus is idle immediately at reset, and the rerun is correct from address 0.
- With SPELL_LOADER_CHECKSUM_EN: bytes 0xFF,0x02 give checksum=0x01 at done.
